// File: rtl/fifo.sv
//------------------------------------------------------------------------------
// Module   : fifo
// Brief    : Single-clock synchronous FIFO with registered read data.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  empty,
  output logic                  full
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_cnt_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_cnt_full = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_out_valid;

  logic w_wr_accept;
  logic w_rd_accept;

  // DEPTH is a power of two, so count==DEPTH is exactly the MSB pattern.
  assign empty = (r_count == '0);
  assign full  = (r_count == c_cnt_full);

  assign w_wr_accept = wr & ~full;
  assign w_rd_accept = rd & ~empty;

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;

  // Storage carries no reset; writes are blocked while clear is held low.
  always_ff @(posedge clk) begin
    if (w_wr_accept && clear) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_count          <= '0;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_accept) begin
        r_rd_ptr   <= r_rd_ptr + c_ptr_one;
        r_data_out <= r_mem[r_rd_ptr];
      end
      r_data_out_valid <= w_rd_accept;

      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo.sv
//------------------------------------------------------------------------------
// Module   : tb_fifo
// Brief    : Self-checking bench for fifo against a queue-based reference model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;

  logic                  clk;
  logic                  clear;
  logic                  wr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  empty;
  logic                  full;

  fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .clear          (clear),
    .wr             (wr),
    .data_in        (data_in),
    .rd             (rd),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .empty          (empty),
    .full           (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DATA_WIDTH-1:0] m_q[$];
  logic [DATA_WIDTH-1:0] m_dout;
  logic                  m_valid;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".empty"}, 32'(empty), 32'(m_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(m_q.size() == DEPTH));
    check({tag, ".valid"}, 32'(data_out_valid), 32'(m_valid));
    check({tag, ".dout"},  32'(data_out), 32'(m_dout));
  endtask

  // Apply one cycle of requests, advance the model by the FIFO rules, then compare.
  task automatic cycle(input logic w, input logic r, input logic [DATA_WIDTH-1:0] d, input string tag);
    bit was_full;
    bit was_empty;
    wr      = w;
    rd      = r;
    data_in = d;
    @(posedge clk);
    was_full  = (m_q.size() == DEPTH);
    was_empty = (m_q.size() == 0);
    m_valid   = 1'b0;
    if (r && !was_empty) begin
      m_dout  = m_q.pop_front();
      m_valid = 1'b1;
    end
    if (w && !was_full) begin
      m_q.push_back(d);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
  endtask

  initial begin
    int p_wr;
    int p_rd;
    clear   = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    data_in = '0;
    model_reset();

    #23;
    check_outputs("reset");
    @(posedge clk);
    #1;
    clear = 1'b1;

    // Empty FIFO: simultaneous write and read -> only the write lands
    cycle(1'b1, 1'b1, 8'h01, "empty_wr_rd");
    cycle(1'b0, 1'b1, 8'h00, "read_first");
    check("read_first.value", 32'(data_out), 32'h01);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 8'h55, "underflow_rd");
    end
    check("underflow.hold", 32'(data_out), 32'h01);

    // Fill to full, overflow write dropped, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'(i), "fill");
    end
    check("fill.full", 32'(full), 32'h1);
    cycle(1'b1, 1'b0, 8'hAA, "overflow_wr");
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00, "drain");
      check("drain.order", 32'(data_out), 32'(i));
    end
    check("drain.empty", 32'(empty), 32'h1);

    // Full FIFO with simultaneous wr/rd: head read, incoming word dropped
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h20 + i), "refill");
    end
    cycle(1'b1, 1'b1, 8'hEE, "full_wr_rd");
    check("full_wr_rd.head", 32'(data_out), 32'h20);
    check("full_wr_rd.notfull", 32'(full), 32'h0);
    while (m_q.size() > 8) begin
      cycle(1'b0, 1'b1, 8'h00, "trim");
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h40 + i), "mid_wr_rd");
      check("mid_wr_rd.count", 32'(m_q.size()), 32'd8);
    end

    // Asynchronous clear with 5 entries stored
    while (m_q.size() > 5) begin
      cycle(1'b0, 1'b1, 8'h00, "trim5");
    end
    wr = 1'b1;
    rd = 1'b1;
    #2;
    clear = 1'b0;
    #1;
    model_reset();
    check_outputs("async_clear");
    @(posedge clk);
    #1;
    check_outputs("clear_held");
    clear = 1'b1;
    cycle(1'b0, 1'b1, 8'h00, "post_clear_rd");

    // Randomized traffic with phases biased toward filling and draining
    for (int i = 0; i < 600; i++) begin
      case ((i / 100) % 3)
        0:       begin p_wr = 80; p_rd = 30; end
        1:       begin p_wr = 30; p_rd = 80; end
        default: begin p_wr = 50; p_rd = 50; end
      endcase
      cycle(($urandom_range(0, 99) < p_wr), ($urandom_range(0, 99) < p_rd),
            8'($urandom), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set storage entries; must be a power of two, at least 2.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge only.
REQ-004 Port clear, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port wr, input, 1 bit: write request, sampled at the rising edge of clk.
REQ-006 Port data_in, input, DATA_WIDTH bits: write data, sampled with wr.
REQ-007 Port rd, input, 1 bit: read request, sampled at the rising edge of clk.
REQ-008 Port data_out, output, DATA_WIDTH bits: registered read data.
REQ-009 Port data_out_valid, output, 1 bit: high for one cycle when data_out carries a newly read word.
REQ-010 Port empty, output, 1 bit: high when the FIFO holds no entries.
REQ-011 Port full, output, 1 bit: high when the FIFO holds DEPTH entries.

Function
REQ-012 Storage SHALL be a DEPTH x DATA_WIDTH array with write and read pointers of log2(DEPTH) bits; both pointers wrap from DEPTH-1 to 0.
REQ-013 An occupancy counter of log2(DEPTH)+1 bits SHALL track entries, range 0..DEPTH, and never wrap.
REQ-014 A write SHALL be accepted when wr=1 and full=0; data_in is stored at the write pointer and the write pointer increments.
REQ-015 A write with full=1 SHALL be ignored: no storage, pointer or counter change, regardless of rd.
REQ-016 A read SHALL be accepted when rd=1 and empty=0; data_out loads the entry at the read pointer and the read pointer increments.
REQ-017 A read with empty=1 SHALL be ignored: no pointer or counter change, data_out holds, and data_out_valid=0, regardless of wr.
REQ-018 Counter update SHALL use accepted operations only: write only +1; read only -1; both accepted, no change; neither, no change.
REQ-019 Simultaneous wr=1 and rd=1 on an empty FIFO SHALL accept only the write; the counter goes 0->1.
REQ-020 Simultaneous wr=1 and rd=1 on a full FIFO SHALL accept only the read; the counter goes DEPTH->DEPTH-1.
REQ-021 empty SHALL be derived combinationally from the registered counter (count==0); full SHALL be derived the same way (count==DEPTH).
REQ-022 Read latency: data_out and data_out_valid SHALL update at the same clock edge that accepts the read (one-cycle registered output); data_out_valid returns to 0 on the next edge unless another read is accepted.
REQ-023 data_out SHALL hold its last value when no read is accepted.
REQ-024 Flags SHALL reflect an accepted operation from the same edge that performs it; there is no look-ahead and no bypass of write data to data_out.

Reset
REQ-025 While clear=0, state SHALL be forced immediately, independent of clk: pointers=0, counter=0, data_out=0, data_out_valid=0, empty=1, full=0.
REQ-026 Storage array contents SHALL NOT require reset.
REQ-027 Asserting clear mid-operation SHALL discard all stored entries and any request in that cycle.
REQ-028 Normal operation SHALL resume at the first rising edge after clear returns to 1.

Verification
REQ-029 Empty with simultaneous write and read (wr=1, rd=1, data_in=0x01 for one cycle) -> write accepted, read ignored; after the edge, empty=0, count=1, data_out_valid=0.
REQ-030 Following cycle (wr=0, rd=1) -> data_out=0x01, data_out_valid=1, empty=1.
REQ-031 rd=1 held for 10 more cycles on an empty FIFO -> data_out_valid=0, empty stays 1, data_out holds 0x01, no counter underflow.
REQ-032 16 consecutive writes of 0x00..0x0F -> full=1 after the 16th; a 17th write of 0xAA is ignored; 16 reads then return 0x00..0x0F in order; empty=1 after the last read.
REQ-033 Full FIFO with wr=1 and rd=1 -> head word read out, full deasserts, incoming word dropped; with 8 entries, simultaneous wr/rd -> count stays 8.
REQ-034 Drive clear=0 between clock edges with 5 entries stored -> outputs reach reset values without a clock edge; after release, the next read is ignored (empty=1).
